l1mtx_dec_param: RTL

- Parametrised input-stage decoder for the L1 AHB bus matrix, successor to the fixed 4-port decoder.
- Maps each input-port address onto one of NUM_PORTS output stages using per-port base/mask regions; unmapped addresses go to an internal two-cycle ERROR default slave.
- Muxes the data-phase response back to the input stage.
- Adds a fault-capture register and a saturating fault counter for software diagnostics.

---
 rtl/l1mtx_dec_param.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/l1mtx_dec_param.sv
// Parametrised L1 bus-matrix input-stage decoder: region decode, data-phase response mux,
// two-cycle ERROR default slave and software-visible fault capture.
module l1mtx_dec_param #(
  parameter int                      NUM_PORTS = 4,
  parameter logic [22*NUM_PORTS-1:0] ADDR_BASE = {NUM_PORTS{22'h0}},
  parameter logic [22*NUM_PORTS-1:0] ADDR_MASK = {NUM_PORTS{22'h3FFFFF}},
  parameter int                      DATA_W    = 32,
  parameter int                      RUSER_W   = 32,
  parameter int                      CNT_W     = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HREADYS,
  input  logic                         sel_dec,
  input  logic [21:0]                  decode_addr_dec,
  input  logic [1:0]                   trans_dec,
  input  logic [NUM_PORTS-1:0]         active_dec_in,
  input  logic [NUM_PORTS-1:0]         readyout_dec_in,
  input  logic [2*NUM_PORTS-1:0]       resp_dec_in,
  input  logic [DATA_W*NUM_PORTS-1:0]  rdata_dec_in,
  input  logic [RUSER_W*NUM_PORTS-1:0] ruser_dec_in,
  output logic [NUM_PORTS-1:0]         sel_dec_out,
  output logic                         active_dec,
  output logic                         HREADYOUTS,
  output logic [1:0]                   HRESPS,
  output logic [DATA_W-1:0]            HRDATAS,
  output logic [RUSER_W-1:0]           HRUSERS,
  input  logic                         fault_clr,
  output logic                         fault_vld,
  output logic [21:0]                  fault_addr,
  output logic [CNT_W-1:0]             fault_cnt
);

  // Port encodings 0..7 are real output stages; DFT and NONE sit above them.
  localparam logic [3:0] P_DFT  = 4'd8;
  localparam logic [3:0] P_NONE = 4'd9;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [3:0] addr_port;
  logic [3:0] data_port;
  logic       sel_dft;
  logic       dft_req;
  logic       dft_ready;
  logic [1:0] dft_resp;
  logic       fault_trig;
  ds_state_t  state, state_nxt;

  // Address phase: descending scan leaves the lowest matching index; an IDLE
  // transfer stays with the port currently owning the data phase.
  always_comb begin
    addr_port = P_DFT;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((decode_addr_dec & ADDR_MASK[22*i +: 22]) == ADDR_BASE[22*i +: 22])
        addr_port = 4'(i);
    end
    if (trans_dec == 2'b00 && data_port < P_DFT)
      addr_port = data_port;
  end

  always_comb begin
    sel_dec_out = '0;
    active_dec  = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == 4'(i)) begin
        sel_dec_out[i] = sel_dec;
        active_dec     = active_dec_in[i];
      end
    end
  end

  assign sel_dft = sel_dec & (addr_port == P_DFT);
  assign dft_req = sel_dft & HREADYS & trans_dec[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     data_port <= P_NONE;
    else if (HREADYS) data_port <= addr_port;
  end

  // Data phase: NONE leaves the bus in its idle OKAY state.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 2'b00;
    HRDATAS    = '0;
    HRUSERS    = '0;
    if (data_port == P_DFT) begin
      HREADYOUTS = dft_ready;
      HRESPS     = dft_resp;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == 4'(i)) begin
        HREADYOUTS = readyout_dec_in[i];
        HRESPS     = resp_dec_in[2*i +: 2];
        HRDATAS    = rdata_dec_in[DATA_W*i +: DATA_W];
        HRUSERS    = ruser_dec_in[RUSER_W*i +: RUSER_W];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= DS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dft_ready = 1'b1;
    dft_resp  = 2'b00;
    case (state)
      DS_IDLE: if (dft_req) state_nxt = DS_ERR1;
      DS_ERR1: begin
        dft_ready = 1'b0;
        dft_resp  = 2'b01;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        dft_resp  = 2'b01;
        state_nxt = dft_req ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  assign fault_trig = (state != DS_ERR1) & dft_req;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_vld  <= 1'b0;
      fault_cnt  <= '0;
      fault_addr <= '0;
    end else begin
      if (fault_clr) begin
        fault_vld <= fault_trig;
        fault_cnt <= fault_trig ? CNT_W'(1) : '0;
      end else if (fault_trig) begin
        fault_vld <= 1'b1;
        if (fault_cnt != {CNT_W{1'b1}}) fault_cnt <= fault_cnt + CNT_W'(1);
      end
      if (fault_trig) fault_addr <= decode_addr_dec;
    end
  end

endmodule
